// File: rtl/cache_bus_arbiter.sv
// Memory-bus arbiter between icache refills and dcache refills/uncached accesses; assembles refill lines.
// Optional round-robin between icache and dcache classes when CACHE_ARB_RR_EN is defined.
module cache_bus_arbiter #(
  parameter int unsigned BEATS  = 8,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ic_rreq_i,
  input  logic [ADDR_W-1:0]       ic_addr_i,
  input  logic                    dc_rreq_i,
  input  logic                    dc_uc_rreq_i,
  input  logic                    dc_uc_wreq_i,
  input  logic [ADDR_W-1:0]       dc_addr_i,
  input  logic [31:0]             dc_wdata_i,
  input  logic [3:0]              dc_wstrb_i,
  output logic                    ic_rend_o,
  output logic                    dc_rend_o,
  output logic                    dc_wend_o,
  output logic [BEATS*32-1:0]     line_o,
  output logic                    bus_req_o,
  output logic                    bus_wr_o,
  output logic [$clog2(BEATS)-1:0] bus_len_o,
  output logic [ADDR_W-1:0]       bus_addr_o,
  output logic [31:0]             bus_wdata_o,
  output logic [3:0]              bus_wstrb_o,
  input  logic                    bus_ack_i,
  input  logic                    bus_rvalid_i,
  input  logic [31:0]             bus_rdata_i,
  input  logic                    bus_rlast_i,
  input  logic                    bus_wdone_i
);

  localparam int unsigned CNT_W = $clog2(BEATS);
  localparam int unsigned OFF_W = $clog2(BEATS * 4);

  typedef enum logic [1:0] {IDLE, ADDR, RDATA, WRESP} state_t;
  typedef enum logic [1:0] {SRC_IC, SRC_DC, SRC_UCR, SRC_UCW} src_t;

  state_t                 state, state_n;
  src_t                   src, src_n, dc_sel;
  logic                   grant, ic_wins, dc_any, any_end;
  logic                   bus_req_n, ic_rend_n, dc_rend_n, dc_wend_n;
  logic [CNT_W-1:0]       beat_cnt;
  logic [BEATS-1:0][31:0] line_q;
  logic [ADDR_W-1:0]      win_addr;

`ifdef CACHE_ARB_RR_EN
  logic last_ic;
`endif

  assign line_o = line_q;

  // Arbitration, next state and next registered outputs
  always_comb begin
    state_n   = state;
    src_n     = src;
    grant     = 1'b0;
    dc_any    = dc_uc_wreq_i | dc_uc_rreq_i | dc_rreq_i;
    any_end   = ic_rend_o | dc_rend_o | dc_wend_o;
    dc_sel    = dc_uc_wreq_i ? SRC_UCW : (dc_uc_rreq_i ? SRC_UCR : SRC_DC);
`ifdef CACHE_ARB_RR_EN
    ic_wins   = ic_rreq_i & (~dc_any | ~last_ic);
`else
    ic_wins   = ic_rreq_i & ~dc_any;
`endif
    win_addr  = ic_wins ? ic_addr_i : dc_addr_i;
    ic_rend_n = 1'b0;
    dc_rend_n = 1'b0;
    dc_wend_n = 1'b0;

    case (state)
      IDLE: begin
        // A requester still sees its end pulse this cycle; hold off one cycle
        if (!any_end && (ic_rreq_i || dc_any)) begin
          grant   = 1'b1;
          src_n   = ic_wins ? SRC_IC : dc_sel;
          state_n = ADDR;
        end
      end
      ADDR: begin
        if (bus_ack_i) state_n = (src == SRC_UCW) ? WRESP : RDATA;
      end
      RDATA: begin
        if (bus_rvalid_i && bus_rlast_i) begin
          state_n   = IDLE;
          ic_rend_n = (src == SRC_IC);
          dc_rend_n = (src != SRC_IC);
        end
      end
      WRESP: begin
        if (bus_wdone_i) begin
          state_n   = IDLE;
          dc_wend_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    bus_req_n = (state_n == ADDR);
  end

  // State, control outputs and latched transaction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      src         <= SRC_IC;
      bus_req_o   <= 1'b0;
      ic_rend_o   <= 1'b0;
      dc_rend_o   <= 1'b0;
      dc_wend_o   <= 1'b0;
      bus_wr_o    <= 1'b0;
      bus_len_o   <= '0;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
      bus_wstrb_o <= '0;
    end else begin
      state     <= state_n;
      src       <= src_n;
      bus_req_o <= bus_req_n;
      ic_rend_o <= ic_rend_n;
      dc_rend_o <= dc_rend_n;
      dc_wend_o <= dc_wend_n;
      if (grant) begin
        bus_wr_o    <= (src_n == SRC_UCW);
        bus_wdata_o <= dc_wdata_i;
        bus_wstrb_o <= dc_wstrb_i;
        if (src_n == SRC_IC || src_n == SRC_DC) begin
          bus_addr_o <= {win_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
          bus_len_o  <= CNT_W'(BEATS - 1);
        end else begin
          bus_addr_o <= win_addr;
          bus_len_o  <= '0;
        end
      end
    end
  end

  // Refill buffer: beat counter saturates at the transaction length
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt <= '0;
      line_q   <= '0;
    end else if (state == RDATA && bus_rvalid_i) begin
      line_q[beat_cnt] <= bus_rdata_i;
      if (bus_rlast_i)
        beat_cnt <= '0;
      else if (beat_cnt < bus_len_o)
        beat_cnt <= beat_cnt + CNT_W'(1);
    end
  end

`ifdef CACHE_ARB_RR_EN
  // Class served by the most recent grant; loses the next tie
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        last_ic <= 1'b1;
    else if (grant) last_ic <= ic_wins;
  end
`endif

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Directed self-checking bench for cache_bus_arbiter (default fixed-priority build).
module tb_cache_bus_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         ic_rreq_i, dc_rreq_i, dc_uc_rreq_i, dc_uc_wreq_i;
  logic [31:0]  ic_addr_i, dc_addr_i, dc_wdata_i;
  logic [3:0]   dc_wstrb_i;
  logic         ic_rend_o, dc_rend_o, dc_wend_o;
  logic [255:0] line_o;
  logic         bus_req_o, bus_wr_o;
  logic [2:0]   bus_len_o;
  logic [31:0]  bus_addr_o, bus_wdata_o;
  logic [3:0]   bus_wstrb_o;
  logic         bus_ack_i, bus_rvalid_i, bus_rlast_i, bus_wdone_i;
  logic [31:0]  bus_rdata_i;

  int n_chk  = 0;
  int n_fail = 0;

  cache_bus_arbiter dut (
    .clk(clk), .rst(rst),
    .ic_rreq_i(ic_rreq_i), .ic_addr_i(ic_addr_i),
    .dc_rreq_i(dc_rreq_i), .dc_uc_rreq_i(dc_uc_rreq_i), .dc_uc_wreq_i(dc_uc_wreq_i),
    .dc_addr_i(dc_addr_i), .dc_wdata_i(dc_wdata_i), .dc_wstrb_i(dc_wstrb_i),
    .ic_rend_o(ic_rend_o), .dc_rend_o(dc_rend_o), .dc_wend_o(dc_wend_o),
    .line_o(line_o),
    .bus_req_o(bus_req_o), .bus_wr_o(bus_wr_o), .bus_len_o(bus_len_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o), .bus_wstrb_o(bus_wstrb_o),
    .bus_ack_i(bus_ack_i), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i),
    .bus_rlast_i(bus_rlast_i), .bus_wdone_i(bus_wdone_i)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word(input int k);
    return line_o[32*k +: 32];
  endfunction

  // Handshake in ADDR after the given number of wait cycles
  task automatic ack_after(input int wait_cyc);
    repeat (wait_cyc) step();
    bus_ack_i = 1'b1;
    step();
    bus_ack_i = 1'b0;
  endtask

  // n read beats base+i, rlast on the last, 'gap' idle cycles between beats
  task automatic beats(input int n, input logic [31:0] base, input int gap);
    for (int i = 0; i < n; i++) begin
      bus_rvalid_i = 1'b1;
      bus_rdata_i  = base + 32'(i);
      bus_rlast_i  = (i == n - 1);
      step();
      bus_rvalid_i = 1'b0;
      bus_rlast_i  = 1'b0;
      if (i != n - 1) repeat (gap) step();
    end
  endtask

  initial begin
    rst = 1'b1;
    {ic_rreq_i, dc_rreq_i, dc_uc_rreq_i, dc_uc_wreq_i} = '0;
    ic_addr_i = '0; dc_addr_i = '0; dc_wdata_i = '0; dc_wstrb_i = '0;
    {bus_ack_i, bus_rvalid_i, bus_rlast_i, bus_wdone_i} = '0;
    bus_rdata_i = '0;
    step(); step();
    rst = 1'b0;
    chk("rst_req", bus_req_o, 0);
    chk("rst_line", line_o, 0);
    chk("rst_ends", {ic_rend_o, dc_rend_o, dc_wend_o}, 0);

    // 1: icache line refill
    ic_rreq_i = 1'b1; ic_addr_i = 32'h1FC0_0024;
    step();
    chk("t1_req", bus_req_o, 1);
    chk("t1_addr", bus_addr_o, 32'h1FC0_0020);
    chk("t1_len", bus_len_o, 7);
    chk("t1_wr", bus_wr_o, 0);
    ack_after(0);
    chk("t1_req_drop", bus_req_o, 0);
    beats(8, 32'h0, 0);
    chk("t1_ic_rend", ic_rend_o, 1);
    chk("t1_dc_rend", dc_rend_o, 0);
    chk("t1_w0", word(0), 32'h0);
    chk("t1_w7", word(7), 32'h7);
    ic_rreq_i = 1'b0;
    step();
    chk("t1_rend_pulse", ic_rend_o, 0);
    chk("t1_idle_req", bus_req_o, 0);

    // 2: uncached store
    dc_uc_wreq_i = 1'b1; dc_addr_i = 32'hBFAF_F002; dc_wdata_i = 32'h1234_5678; dc_wstrb_i = 4'b1100;
    step();
    chk("t2_req", bus_req_o, 1);
    chk("t2_wr", bus_wr_o, 1);
    chk("t2_len", bus_len_o, 0);
    chk("t2_addr", bus_addr_o, 32'hBFAF_F002);
    chk("t2_wdata", bus_wdata_o, 32'h1234_5678);
    chk("t2_wstrb", bus_wstrb_o, 4'b1100);
    ack_after(0);
    bus_rvalid_i = 1'b1;
    step();
    bus_rvalid_i = 1'b0;
    chk("t2_rvalid_ignored", dc_rend_o, 0);
    chk("t2_line_untouched", word(0), 32'h0);
    bus_wdone_i = 1'b1;
    step();
    bus_wdone_i = 1'b0;
    chk("t2_wend", dc_wend_o, 1);
    dc_uc_wreq_i = 1'b0;
    step();
    chk("t2_wend_pulse", dc_wend_o, 0);

    // 3: simultaneous icache and dcache refill, dcache first
    ic_rreq_i = 1'b1; ic_addr_i = 32'h0000_1040;
    dc_rreq_i = 1'b1; dc_addr_i = 32'h0000_2064;
    step();
    chk("t3_dc_addr", bus_addr_o, 32'h0000_2060);
    chk("t3_dc_wr", bus_wr_o, 0);
    ack_after(0);
    beats(8, 32'h100, 0);
    chk("t3_dc_rend", dc_rend_o, 1);
    chk("t3_no_ic_rend", ic_rend_o, 0);
    chk("t3_dc_w5", word(5), 32'h105);
    dc_rreq_i = 1'b0;
    step();
    chk("t3_gap_req", bus_req_o, 0);
    step();
    chk("t3_ic_req", bus_req_o, 1);
    chk("t3_ic_addr", bus_addr_o, 32'h0000_1040);
    ack_after(0);
    beats(8, 32'h200, 0);
    chk("t3_ic_rend", ic_rend_o, 1);
    chk("t3_ic_w3", word(3), 32'h203);
    ic_rreq_i = 1'b0;
    step();

    // 4: delayed ack, gapped beats
    ic_rreq_i = 1'b1; ic_addr_i = 32'h0000_3018;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_req", bus_req_o, 1);
      chk("t4_hold_addr", bus_addr_o, 32'h0000_3000);
      chk("t4_hold_len", bus_len_o, 7);
      step();
    end
    chk("t4_hold_req_last", bus_req_o, 1);
    ack_after(0);
    chk("t4_req_drop", bus_req_o, 0);
    beats(8, 32'h300, 2);
    chk("t4_rend", ic_rend_o, 1);
    chk("t4_w0", word(0), 32'h300);
    chk("t4_w4", word(4), 32'h304);
    chk("t4_w7", word(7), 32'h307);
    ic_rreq_i = 1'b0;
    step();
    chk("t4_single_pulse", ic_rend_o, 0);

    // 5: uncached load, one beat; other words keep stale data
    dc_uc_rreq_i = 1'b1; dc_addr_i = 32'hBFD0_F010;
    step();
    chk("t5_addr", bus_addr_o, 32'hBFD0_F010);
    chk("t5_len", bus_len_o, 0);
    ack_after(0);
    beats(1, 32'hDEAD_BEEF, 0);
    chk("t5_rend", dc_rend_o, 1);
    chk("t5_w0", word(0), 32'hDEAD_BEEF);
    chk("t5_w1_stale", word(1), 32'h301);
    dc_uc_rreq_i = 1'b0;
    step();
    chk("t5_rend_pulse", dc_rend_o, 0);

    // 7: extra beats saturate on word 7
    ic_rreq_i = 1'b1; ic_addr_i = 32'h0000_4000;
    step();
    ack_after(0);
    beats(10, 32'hA0, 0);
    chk("t7_rend", ic_rend_o, 1);
    chk("t7_w6", word(6), 32'hA6);
    chk("t7_w7_sat", word(7), 32'hA9);
    ic_rreq_i = 1'b0;
    step();

    // 8: early rlast on a dcache line
    dc_rreq_i = 1'b1; dc_addr_i = 32'h0000_5000;
    step();
    ack_after(0);
    beats(3, 32'hB0, 0);
    chk("t8_rend", dc_rend_o, 1);
    chk("t8_w2", word(2), 32'hB2);
    chk("t8_w3_stale", word(3), 32'hA3);
    dc_rreq_i = 1'b0;
    step();

    // 6: reset after beat 3, then a clean refill
    ic_rreq_i = 1'b1; ic_addr_i = 32'h0000_6000;
    step();
    ack_after(0);
    for (int i = 0; i < 4; i++) begin
      bus_rvalid_i = 1'b1; bus_rdata_i = 32'hC0 + 32'(i);
      step();
    end
    bus_rvalid_i = 1'b0;
    rst = 1'b1;
    #1;
    chk("t6_rst_req", bus_req_o, 0);
    chk("t6_rst_line", line_o, 0);
    step();
    chk("t6_no_pulse", {ic_rend_o, dc_rend_o, dc_wend_o}, 0);
    rst = 1'b0;
    step();
    chk("t6_new_req", bus_req_o, 1);
    chk("t6_new_addr", bus_addr_o, 32'h0000_6000);
    ack_after(0);
    beats(8, 32'hD0, 0);
    chk("t6_rend", ic_rend_o, 1);
    chk("t6_w7", word(7), 32'hD7);
    ic_rreq_i = 1'b0;
    step();
    chk("t6_end_pulse", ic_rend_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
